// File: rtl/hyp_line_cache_if.sv
// Bus bundle between the CPU-side decoder, the line cache and the hyper_xface controller.
// slave = the cache's view; master = the surrounding CPU decoder / controller view.
interface hyp_line_cache_if;
  logic        cpu_valid;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        hyp_rd_req;
  logic        hyp_wr_req;
  logic [31:0] hyp_addr;
  logic [31:0] hyp_wr_d;
  logic [3:0]  hyp_wr_byte_en;
  logic [5:0]  hyp_rd_num_dwords;
  logic [31:0] hyp_rd_d;
  logic        hyp_rd_rdy;
  logic        hyp_busy;

  modport slave (
    input  cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
    output cpu_ready, cpu_rdata,
    output hyp_rd_req, hyp_wr_req, hyp_addr, hyp_wr_d, hyp_wr_byte_en, hyp_rd_num_dwords,
    input  hyp_rd_d, hyp_rd_rdy, hyp_busy
  );

  modport master (
    output cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
    input  cpu_ready, cpu_rdata,
    input  hyp_rd_req, hyp_wr_req, hyp_addr, hyp_wr_d, hyp_wr_byte_en, hyp_rd_num_dwords,
    output hyp_rd_d, hyp_rd_rdy, hyp_busy
  );
endinterface

// File: rtl/hyp_line_cache.sv
// Direct-mapped, write-through, no-write-allocate read cache in front of hyper_xface.
// Misses fetch a whole 4-dword line in one burst; hits answer two cycles after the request.
module hyp_line_cache #(
  parameter int LINES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  hyp_line_cache_if.slave        bus,
  input  logic                   inv,
  output logic [15:0]            hit_cnt,
  output logic [15:0]            miss_cnt
);
  localparam int IW = $clog2(LINES);
  localparam int TW = 24 - IW;

  typedef enum logic [2:0] {IDLE, LOOKUP, FILL_REQ, FILL_WAIT, WR_REQ, WR_WAIT, RESP} state_t;

  state_t              state;
  logic [31:0]         addr_q;
  logic [31:0]         wdata_q;
  logic [3:0]          wstrb_q;
  logic [TW-1:0]       tags [LINES];
  logic [LINES-1:0]    valid;
  logic [31:0]         mem [LINES*4];
  logic [31:0]         rd_word_p1;
  logic [31:0]         resp_q;
  logic [2:0]          cnt;
  logic                kill;

  logic [IW-1:0]       idx_q;
  logic [1:0]          off_q;
  logic [TW-1:0]       tag_q;
  logic                is_rd;
  logic                hit;
  logic                fill_we;
  logic [2:0]          cnt_nxt;
  logic [31:0]         resp_nxt;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] strb);
    logic [31:0] w;
    w = old_w;
    for (int b = 0; b < 4; b++)
      if (strb[b]) w[8*b +: 8] = new_w[8*b +: 8];
    return w;
  endfunction

  assign idx_q    = addr_q[4+IW-1:4];
  assign off_q    = addr_q[3:2];
  assign tag_q    = addr_q[27:4+IW];
  assign is_rd    = (wstrb_q == 4'h0);
  assign hit      = valid[idx_q] && (tags[idx_q] == tag_q);
  // Beats past the fourth are dropped so a long burst cannot spill into the next line.
  assign fill_we  = (state == FILL_WAIT) && bus.hyp_rd_rdy && !cnt[2];
  assign cnt_nxt  = cnt + {2'b00, fill_we};
  assign resp_nxt = (fill_we && (cnt[1:0] == off_q)) ? bus.hyp_rd_d : resp_q;

  assign bus.hyp_rd_num_dwords = 6'd4;

  // Request capture, registered data-array read and line/tag writes
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.cpu_valid) begin
      addr_q     <= bus.cpu_addr;
      wdata_q    <= bus.cpu_wdata;
      wstrb_q    <= bus.cpu_wstrb;
      rd_word_p1 <= mem[{bus.cpu_addr[4+IW-1:4], bus.cpu_addr[3:2]}];
    end
    if (state == LOOKUP && !is_rd && hit)
      mem[{idx_q, off_q}] <= merge_bytes(rd_word_p1, wdata_q, wstrb_q);
    if (fill_we)
      mem[{idx_q, cnt[1:0]}] <= bus.hyp_rd_d;
    if (state == FILL_REQ) begin
      tags[idx_q] <= tag_q;
      resp_q      <= '0;
    end else if (fill_we) begin
      resp_q      <= resp_nxt;
    end
  end

  // Control FSM with registered bus strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      valid              <= '0;
      cnt                <= '0;
      kill               <= 1'b0;
      bus.cpu_ready      <= 1'b0;
      bus.cpu_rdata      <= '0;
      bus.hyp_rd_req     <= 1'b0;
      bus.hyp_wr_req     <= 1'b0;
      bus.hyp_addr       <= '0;
      bus.hyp_wr_d       <= '0;
      bus.hyp_wr_byte_en <= '0;
      hit_cnt            <= '0;
      miss_cnt           <= '0;
    end else begin
      bus.cpu_ready  <= 1'b0;
      bus.hyp_rd_req <= 1'b0;
      bus.hyp_wr_req <= 1'b0;
      case (state)
        IDLE: if (bus.cpu_valid) state <= LOOKUP;
        LOOKUP: begin
          if (!is_rd) begin
            bus.hyp_wr_req     <= 1'b1;
            bus.hyp_addr       <= addr_q;
            bus.hyp_wr_d       <= wdata_q;
            bus.hyp_wr_byte_en <= wstrb_q;
            state              <= WR_REQ;
          end else if (hit) begin
            bus.cpu_ready <= 1'b1;
            bus.cpu_rdata <= rd_word_p1;
            hit_cnt       <= hit_cnt + 16'd1;
            state         <= RESP;
          end else begin
            bus.hyp_rd_req <= 1'b1;
            bus.hyp_addr   <= {addr_q[31:4], 4'h0};
            miss_cnt       <= miss_cnt + 16'd1;
            state          <= FILL_REQ;
          end
        end
        FILL_REQ: begin
          // The line is overwritten beat by beat, so it must not hit until the fill completes.
          valid[idx_q] <= 1'b0;
          cnt          <= '0;
          kill         <= 1'b0;
          state        <= FILL_WAIT;
        end
        FILL_WAIT: begin
          cnt <= cnt_nxt;
          if (!bus.hyp_busy) begin
            bus.cpu_ready <= 1'b1;
            bus.cpu_rdata <= resp_nxt;
            if (cnt_nxt == 3'd4 && !kill) valid[idx_q] <= 1'b1;
            state <= RESP;
          end
        end
        WR_REQ: state <= WR_WAIT;
        WR_WAIT: begin
          if (!bus.hyp_busy) begin
            bus.cpu_ready <= 1'b1;
            bus.cpu_rdata <= '0;
            state         <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // Invalidate overrides any validate issued in the same cycle
      if (inv) begin
        valid <= '0;
        if (state == FILL_REQ || state == FILL_WAIT) kill <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_hyp_line_cache.sv
// Bench for hyp_line_cache: behavioural HyperRAM controller plus a queue of expected read data.
module tb_hyp_line_cache;
  localparam int LINES = 16;

  logic        clk;
  logic        rst;
  logic        inv;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  hyp_line_cache_if bus ();

  hyp_line_cache #(.LINES(LINES)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .inv      (inv),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] exp_q [$];
  logic [31:0] hmem [logic [31:0]];

  int          rd_req_n = 0;
  int          wr_req_n = 0;
  logic [31:0] rd_addr_last;
  logic [5:0]  rd_nd_last;
  logic [31:0] wr_addr_last;
  logic [31:0] wr_d_last;
  logic [3:0]  wr_be_last;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    if (hmem.exists(k)) return hmem[k];
    return {~k[15:0], k[15:0]};
  endfunction

  always @(negedge clk) begin
    if (bus.hyp_rd_req) begin
      rd_req_n++;
      rd_addr_last = bus.hyp_addr;
      rd_nd_last   = bus.hyp_rd_num_dwords;
    end
    if (bus.hyp_wr_req) begin
      wr_req_n++;
      wr_addr_last = bus.hyp_addr;
      wr_d_last    = bus.hyp_wr_d;
      wr_be_last   = bus.hyp_wr_byte_en;
    end
  end

  // HyperRAM controller model: 2 idle cycles, 4 data beats, then busy drops; aborts on rst.
  initial begin
    bus.hyp_busy   = 1'b0;
    bus.hyp_rd_rdy = 1'b0;
    bus.hyp_rd_d   = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst && bus.hyp_rd_req) begin
        automatic logic [31:0] a  = bus.hyp_addr;
        automatic bit          ab = 1'b0;
        bus.hyp_busy = 1'b1;
        for (int k = 0; k < 7 && !ab; k++) begin
          @(posedge clk);
          if (rst) ab = 1'b1;
          else begin
            #1;
            if (k >= 2 && k < 6) begin
              bus.hyp_rd_rdy = 1'b1;
              bus.hyp_rd_d   = mem_word(a + 32'(4 * (k - 2)));
            end else begin
              bus.hyp_rd_rdy = 1'b0;
            end
          end
        end
        if (ab) #1;
        bus.hyp_rd_rdy = 1'b0;
        bus.hyp_busy   = 1'b0;
      end else if (!rst && bus.hyp_wr_req) begin
        automatic logic [31:0] k = {bus.hyp_addr[31:2], 2'b00};
        automatic logic [31:0] w = mem_word(k);
        automatic bit          ab = 1'b0;
        for (int b = 0; b < 4; b++)
          if (bus.hyp_wr_byte_en[b]) w[8*b +: 8] = bus.hyp_wr_d[8*b +: 8];
        hmem[k] = w;
        bus.hyp_busy = 1'b1;
        for (int c = 0; c < 2 && !ab; c++) begin
          @(posedge clk);
          if (rst) ab = 1'b1;
          else #1;
        end
        if (ab) #1;
        bus.hyp_busy = 1'b0;
      end
    end
  end

  // Issue one CPU access; called and returns at 1 time unit after a rising edge.
  task automatic cpu_op(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                        output logic [31:0] rd, output int lat);
    bit done;
    bus.cpu_valid = 1'b1;
    bus.cpu_addr  = a;
    bus.cpu_wdata = wd;
    bus.cpu_wstrb = ws;
    lat  = 0;
    done = 1'b0;
    while (!done) begin
      @(posedge clk); #1;
      lat++;
      if (bus.cpu_ready) done = 1'b1;
      else if (lat > 200) begin
        n_chk++; n_fail++;
        $display("FAIL cpu_op_timeout addr=%h: no cpu_ready after %0d cycles, required within 200", a, lat);
        done = 1'b1;
      end
    end
    rd = bus.cpu_rdata;
    bus.cpu_valid = 1'b0;
    bus.cpu_wstrb = 4'h0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (bus.cpu_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_ready: got %b want 0", bus.cpu_ready); end
    n_chk++; if (bus.cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_cpu_rdata: got %h want 0", bus.cpu_rdata); end
    n_chk++; if ({bus.hyp_rd_req, bus.hyp_wr_req} !== 2'b00) begin n_fail++; $display("FAIL rst_req: got %b want 00", {bus.hyp_rd_req, bus.hyp_wr_req}); end
    n_chk++; if ({bus.hyp_addr, bus.hyp_wr_d} !== 64'h0) begin n_fail++; $display("FAIL rst_addr_wd: got %h/%h want 0/0", bus.hyp_addr, bus.hyp_wr_d); end
    n_chk++; if (bus.hyp_wr_byte_en !== 4'h0) begin n_fail++; $display("FAIL rst_byte_en: got %h want 0", bus.hyp_wr_byte_en); end
    n_chk++; if (bus.hyp_rd_num_dwords !== 6'd4) begin n_fail++; $display("FAIL rst_num_dwords: got %0d want 4", bus.hyp_rd_num_dwords); end
    n_chk++; if ({hit_cnt, miss_cnt} !== 32'h0) begin n_fail++; $display("FAIL rst_counters: got %0d/%0d want 0/0", hit_cnt, miss_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_read_miss_hit();
    logic [31:0] rd, exp;
    int lat, r0;
    r0 = rd_req_n;
    exp_q.push_back(32'h11);
    cpu_op(32'h5000_0010, 32'h0, 4'h0, rd, lat);
    exp = exp_q.pop_front();
    n_chk++; if (rd !== exp) begin n_fail++; $display("FAIL miss_rdata: got %h want %h", rd, exp); end
    n_chk++; if (rd_req_n - r0 !== 1) begin n_fail++; $display("FAIL miss_req_count: got %0d want 1", rd_req_n - r0); end
    n_chk++; if (rd_addr_last !== 32'h5000_0010 || rd_nd_last !== 6'd4) begin n_fail++; $display("FAIL miss_req_addr: got %h/%0d want 50000010/4", rd_addr_last, rd_nd_last); end
    n_chk++; if (miss_cnt !== 16'd1) begin n_fail++; $display("FAIL miss_cnt: got %0d want 1", miss_cnt); end
    r0 = rd_req_n;
    exp_q.push_back(32'h33);
    cpu_op(32'h5000_0018, 32'h0, 4'h0, rd, lat);
    exp = exp_q.pop_front();
    n_chk++; if (rd !== exp) begin n_fail++; $display("FAIL hit_rdata: got %h want %h", rd, exp); end
    n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL hit_latency: got %0d want 2", lat); end
    n_chk++; if (rd_req_n !== r0) begin n_fail++; $display("FAIL hit_no_req: got %0d requests want 0", rd_req_n - r0); end
    n_chk++; if (hit_cnt !== 16'd1) begin n_fail++; $display("FAIL hit_cnt: got %0d want 1", hit_cnt); end
  endtask

  task automatic test_write_hit();
    logic [31:0] rd, exp;
    int lat, w0, r0;
    w0 = wr_req_n;
    exp_q.push_back(32'h0);
    cpu_op(32'h5000_0014, 32'hAABB_CCDD, 4'b0011, rd, lat);
    exp = exp_q.pop_front();
    n_chk++; if (rd !== exp) begin n_fail++; $display("FAIL wr_rdata: got %h want %h", rd, exp); end
    n_chk++; if (wr_req_n - w0 !== 1) begin n_fail++; $display("FAIL wr_req_count: got %0d want 1", wr_req_n - w0); end
    n_chk++; if ({wr_addr_last, wr_d_last, wr_be_last} !== {32'h5000_0014, 32'hAABB_CCDD, 4'h3}) begin
      n_fail++; $display("FAIL wr_req_fields: got %h/%h/%h want 50000014/aabbccdd/3", wr_addr_last, wr_d_last, wr_be_last); end
    r0 = rd_req_n;
    exp_q.push_back(32'h0000_CCDD);
    cpu_op(32'h5000_0014, 32'h0, 4'h0, rd, lat);
    exp = exp_q.pop_front();
    n_chk++; if (rd !== exp) begin n_fail++; $display("FAIL wr_hit_update: got %h want %h", rd, exp); end
    n_chk++; if (lat !== 2 || rd_req_n !== r0) begin n_fail++; $display("FAIL wr_hit_reread_hit: got lat %0d reqs %0d want 2/0", lat, rd_req_n - r0); end
  endtask

  task automatic test_write_miss();
    logic [31:0] rd, exp;
    int lat, r0, m0;
    exp_q.push_back(32'h0);
    cpu_op(32'h5000_0100, 32'h1234_5678, 4'hF, rd, lat);
    exp = exp_q.pop_front();
    n_chk++; if (rd !== exp) begin n_fail++; $display("FAIL wmiss_rdata: got %h want %h", rd, exp); end
    r0 = rd_req_n; m0 = int'(miss_cnt);
    exp_q.push_back(32'h1234_5678);
    cpu_op(32'h5000_0100, 32'h0, 4'h0, rd, lat);
    exp = exp_q.pop_front();
    n_chk++; if (rd !== exp) begin n_fail++; $display("FAIL wmiss_read: got %h want %h", rd, exp); end
    n_chk++; if (rd_req_n - r0 !== 1 || int'(miss_cnt) - m0 !== 1) begin
      n_fail++; $display("FAIL wmiss_no_alloc: got reqs %0d misses %0d want 1/1", rd_req_n - r0, int'(miss_cnt) - m0); end
  endtask

  task automatic test_conflict();
    logic [31:0] rd, exp;
    logic [31:0] addrs [3];
    int lat, m0, h0;
    addrs[0] = 32'h5000_0000;
    addrs[1] = 32'h5000_0000 + 32'(16 * LINES);
    addrs[2] = 32'h5000_0000;
    m0 = int'(miss_cnt); h0 = int'(hit_cnt);
    for (int i = 0; i < 3; i++) exp_q.push_back(mem_word(addrs[i]));
    for (int i = 0; i < 3; i++) begin
      cpu_op(addrs[i], 32'h0, 4'h0, rd, lat);
      exp = exp_q.pop_front();
      n_chk++; if (rd !== exp) begin n_fail++; $display("FAIL conflict_rdata[%0d]: got %h want %h", i, rd, exp); end
    end
    n_chk++; if (int'(miss_cnt) - m0 !== 3 || hit_cnt !== 16'(h0)) begin
      n_fail++; $display("FAIL conflict_counts: got misses %0d hits %0d want 3/0", int'(miss_cnt) - m0, int'(hit_cnt) - h0); end
  endtask

  task automatic test_inv_during_fill();
    logic [31:0] rd, exp;
    int lat, r0;
    exp_q.push_back(mem_word(32'h5000_0028));
    fork
      cpu_op(32'h5000_0028, 32'h0, 4'h0, rd, lat);
      begin
        int w;
        w = 0;
        while (!bus.hyp_rd_req && w < 50) begin @(posedge clk); #1; w++; end
        repeat (2) begin @(posedge clk); #1; end
        inv = 1'b1;
        @(posedge clk); #1;
        inv = 1'b0;
      end
    join
    exp = exp_q.pop_front();
    n_chk++; if (rd !== exp) begin n_fail++; $display("FAIL inv_fill_rdata: got %h want %h", rd, exp); end
    r0 = rd_req_n;
    exp_q.push_back(mem_word(32'h5000_0028));
    cpu_op(32'h5000_0028, 32'h0, 4'h0, rd, lat);
    exp = exp_q.pop_front();
    n_chk++; if (rd !== exp) begin n_fail++; $display("FAIL inv_reread_rdata: got %h want %h", rd, exp); end
    n_chk++; if (rd_req_n - r0 !== 1) begin n_fail++; $display("FAIL inv_reread_miss: got %0d requests want 1", rd_req_n - r0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, exp;
    int lat;
    for (int i = 0; i < 4; i++) exp_q.push_back(mem_word(32'h5000_0030 + 32'(4 * i)));
    for (int i = 3; i >= 0; i--) begin
      cpu_op(32'h5000_0030 + 32'(4 * (3 - i)), 32'h0, 4'h0, rd, lat);
      exp = exp_q.pop_front();
      n_chk++; if (rd !== exp) begin n_fail++; $display("FAIL b2b_rdata[%0d]: got %h want %h", 3 - i, rd, exp); end
      if (i < 3) begin
        n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL b2b_hit_latency[%0d]: got %0d want 2", 3 - i, lat); end
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] rd, exp;
    int lat, w, r0;
    bus.cpu_valid = 1'b1;
    bus.cpu_addr  = 32'h5000_0044;
    bus.cpu_wstrb = 4'h0;
    w = 0;
    while (!bus.hyp_rd_req && w < 50) begin @(posedge clk); #1; w++; end
    n_chk++; if (bus.hyp_rd_req !== 1'b1) begin n_fail++; $display("FAIL rstfill_req: got %b want 1", bus.hyp_rd_req); end
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    bus.cpu_valid = 1'b0;
    @(posedge clk); #1;
    n_chk++; if ({bus.cpu_ready, bus.hyp_rd_req, bus.hyp_wr_req} !== 3'b000) begin
      n_fail++; $display("FAIL rstfill_strobes: got %b want 000", {bus.cpu_ready, bus.hyp_rd_req, bus.hyp_wr_req}); end
    n_chk++; if ({bus.hyp_addr, miss_cnt, hit_cnt} !== 64'h0) begin
      n_fail++; $display("FAIL rstfill_regs: got addr %h miss %0d hit %0d want 0/0/0", bus.hyp_addr, miss_cnt, hit_cnt); end
    rst = 1'b0;
    @(posedge clk); #1;
    r0 = rd_req_n;
    exp_q.push_back(mem_word(32'h5000_0044));
    exp_q.push_back(mem_word(32'h5000_0034));
    cpu_op(32'h5000_0044, 32'h0, 4'h0, rd, lat);
    exp = exp_q.pop_front();
    n_chk++; if (rd !== exp) begin n_fail++; $display("FAIL rstfill_reread: got %h want %h", rd, exp); end
    cpu_op(32'h5000_0034, 32'h0, 4'h0, rd, lat);
    exp = exp_q.pop_front();
    n_chk++; if (rd !== exp) begin n_fail++; $display("FAIL rstfill_old_line: got %h want %h", rd, exp); end
    n_chk++; if (miss_cnt !== 16'd2 || rd_req_n - r0 !== 2) begin
      n_fail++; $display("FAIL rstfill_misses: got miss_cnt %0d reqs %0d want 2/2", miss_cnt, rd_req_n - r0); end
  endtask

  initial begin
    hmem[32'h5000_0010] = 32'h11;
    hmem[32'h5000_0014] = 32'h22;
    hmem[32'h5000_0018] = 32'h33;
    hmem[32'h5000_001C] = 32'h44;
    rst = 1'b1;
    inv = 1'b0;
    bus.cpu_valid = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.cpu_wstrb = '0;
    test_reset();
    @(posedge clk); #1;
    test_read_miss_hit();
    test_write_hit();
    test_write_miss();
    test_conflict();
    test_inv_during_fill();
    test_back_to_back();
    test_reset_mid_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "global timeout");
  end
endmodule
